// File: rtl/cpu_pkg.sv
// Shared types and field-position constants for the sequencer and its decoder.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FETCH      = 3'd1,
    S_DECODE     = 3'd2,
    S_EXEC       = 3'd3,
    S_WRITE_BACK = 3'd4,
    S_HALT       = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_LD  = 3'd4,
    OP_ST  = 3'd5,
    OP_BRZ = 3'd6,
    OP_JMP = 3'd7
  } opcode_t;

  // Default instruction layout: opcode in the MSBs, operand below it.
  localparam int DEF_INSTR_W = 8;
  localparam int DEF_OPC_W   = 3;
  localparam int DEF_PC_W    = 5;

  // Operand occupies everything below the opcode field.
  function automatic int operand_w(input int instr_w, input int opc_w);
    return instr_w - opc_w;
  endfunction

endpackage

// File: rtl/instr_dec.sv
// Combinational instruction decoder: splits IR into opcode/operand and class flags.
module instr_dec
  import cpu_pkg::*;
#(
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int OPC_W   = DEF_OPC_W
) (
  input  logic [INSTR_W-1:0]       i_ir,
  output logic [OPC_W-1:0]         o_opcode,
  output logic [INSTR_W-OPC_W-1:0] o_operand,
  output logic                     o_is_alu,
  output logic                     o_is_ld,
  output logic                     o_is_st,
  output logic                     o_is_branch
);

  assign o_opcode    = i_ir[INSTR_W-1 -: OPC_W];
  assign o_operand   = i_ir[INSTR_W-OPC_W-1:0];
  // ADD..OR are the lowest four codes, so one magnitude compare covers them.
  assign o_is_alu    = (o_opcode <= OPC_W'(OP_OR));
  assign o_is_ld     = (o_opcode == OPC_W'(OP_LD));
  assign o_is_st     = (o_opcode == OPC_W'(OP_ST));
  assign o_is_branch = (o_opcode == OPC_W'(OP_BRZ)) || (o_opcode == OPC_W'(OP_JMP));

endmodule

// File: rtl/seq_ctrl.sv
// Multi-cycle control sequencer: owns PC and IR, fetches from program memory,
// and issues one-cycle ALU / accumulator / register-file enables.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// S_IDLE       | waiting for run; forced here while prog_load is high
// S_FETCH      | imem_req high at pc, held until imem_valid
// S_DECODE     | latch op_code / reg_addr from IR
// S_EXEC       | alu_en for ALU ops; branch / jump resolve here
// S_WRITE_BACK | acc_ce (ALU, LD) or reg_ce (ST); then fetch or halt
// S_HALT       | halted high; run restarts from address 0
module seq_ctrl
  import cpu_pkg::*;
#(
  parameter  int INSTR_W  = DEF_INSTR_W,
  parameter  int OPC_W    = DEF_OPC_W,
  parameter  int PC_W     = DEF_PC_W,
  parameter  int NUM_REGS = 4,
  parameter  int WRAP_EN  = 0,
  localparam int RA_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               run,
  input  logic               prog_load,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               acc_zero,
  output logic [OPC_W-1:0]   op_code,
  output logic [RA_W-1:0]    reg_addr,
  output logic               alu_en,
  output logic               acc_ce,
  output logic [NUM_REGS-1:0] reg_ce,
  output logic [PC_W-1:0]    pc,
  output logic               halted,
  output logic [2:0]         state
);

  localparam int OPND_W = operand_w(INSTR_W, OPC_W);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PC_W-1:0]     r_pc;
  logic [PC_W-1:0]     r_iaddr;
  logic [INSTR_W-1:0]  r_ir;
  logic                r_end;
  logic [OPC_W-1:0]    r_op_code;
  logic [RA_W-1:0]     r_reg_addr;
  logic                r_reg_ok;

  logic [OPC_W-1:0]    w_opc;
  logic [OPND_W-1:0]   w_opnd;
  logic                w_is_alu;
  logic                w_is_ld;
  logic                w_is_st;
  logic                w_is_branch;
  logic                w_is_jmp;
  logic                w_take;
  logic                w_jmp_self;

  instr_dec #(
    .INSTR_W (INSTR_W),
    .OPC_W   (OPC_W)
  ) u_dec (
    .i_ir        (r_ir),
    .o_opcode    (w_opc),
    .o_operand   (w_opnd),
    .o_is_alu    (w_is_alu),
    .o_is_ld     (w_is_ld),
    .o_is_st     (w_is_st),
    .o_is_branch (w_is_branch)
  );

  assign w_is_jmp   = (w_opc == OPC_W'(OP_JMP));
  assign w_take     = w_is_branch && (w_is_jmp || acc_zero);
  // r_iaddr is the address the instruction was fetched from, which stays
  // correct even when the end flag suppressed the pc increment.
  assign w_jmp_self = w_is_jmp && (w_opnd[PC_W-1:0] == r_iaddr);

  // Next-state selection; prog_load overrides everything, including run.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:       if (run) w_state_nxt = S_FETCH;
      S_FETCH:      if (imem_valid) w_state_nxt = S_DECODE;
      S_DECODE:     w_state_nxt = S_EXEC;
      S_EXEC:       w_state_nxt = w_jmp_self ? S_HALT : S_WRITE_BACK;
      S_WRITE_BACK: w_state_nxt = r_end ? S_HALT : S_FETCH;
      S_HALT:       if (run) w_state_nxt = S_FETCH;
      default:      w_state_nxt = S_IDLE;
    endcase
    if (prog_load) w_state_nxt = S_IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // PC, IR, end flag and the registered decode fields.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pc       <= '0;
      r_iaddr    <= '0;
      r_ir       <= '0;
      r_end      <= 1'b0;
      r_op_code  <= '0;
      r_reg_addr <= '0;
      r_reg_ok   <= 1'b0;
    end else if (prog_load) begin
      r_pc  <= '0;
      r_end <= 1'b0;
    end else begin
      unique case (r_state)
        S_FETCH: begin
          if (imem_valid) begin
            r_ir    <= imem_rdata;
            r_iaddr <= r_pc;
            // Without wrap, running off the top halts after this instruction.
            if ((r_pc == {PC_W{1'b1}}) && (WRAP_EN == 0)) r_end <= 1'b1;
            else                                          r_pc  <= r_pc + PC_W'(1);
          end
        end
        S_DECODE: begin
          r_op_code  <= w_opc;
          r_reg_addr <= w_opnd[RA_W-1:0];
          r_reg_ok   <= (32'(w_opnd) < NUM_REGS);
        end
        S_EXEC: begin
          // A taken branch redirects the PC, so it is no longer running off the end.
          if (w_take) begin
            r_pc  <= w_opnd[PC_W-1:0];
            r_end <= 1'b0;
          end
        end
        S_HALT: begin
          if (run) begin
            r_pc  <= '0;
            r_end <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Enables are pure state decodes so an async reset clears them at once.
  always_comb begin
    reg_ce = '0;
    if ((r_state == S_WRITE_BACK) && w_is_st && r_reg_ok)
      reg_ce = NUM_REGS'(1) << r_reg_addr;
  end

  assign imem_req  = (r_state == S_FETCH);
  assign imem_addr = r_pc;
  assign alu_en    = (r_state == S_EXEC) && w_is_alu;
  assign acc_ce    = (r_state == S_WRITE_BACK) && (w_is_alu || w_is_ld);
  assign op_code   = r_op_code;
  assign reg_addr  = r_reg_addr;
  assign pc        = r_pc;
  assign halted    = (r_state == S_HALT);
  assign state     = r_state;

endmodule

// File: tb/tb_seq_ctrl.sv
// Self-checking bench for seq_ctrl: directed scenarios plus random programs,
// checked against an instruction-level model of the sequencer.
module tb_seq_ctrl;

  logic clk = 1'b0;
  logic rstn, run, prog_load, imem_valid, acc_zero;
  logic [7:0] mem [32];

  logic       a_req, a_alu, a_acc, a_halt;
  logic [4:0] a_addr, a_pc;
  logic [7:0] a_rdata;
  logic [2:0] a_opc, a_state;
  logic [1:0] a_ra;
  logic [3:0] a_rce;

  logic       b_req, b_alu, b_acc, b_halt;
  logic [4:0] b_addr, b_pc;
  logic [7:0] b_rdata;
  logic [2:0] b_opc, b_state;
  logic [1:0] b_ra;
  logic [3:0] b_rce;

  int nchk = 0;
  int nerr = 0;
  int m_pc;
  bit m_end;

  assign a_rdata = mem[a_addr];
  assign b_rdata = mem[b_addr];

  always #5 clk = ~clk;

  seq_ctrl #(.WRAP_EN(0)) dut_a (
    .clk(clk), .rstn(rstn), .run(run), .prog_load(prog_load),
    .imem_req(a_req), .imem_addr(a_addr), .imem_valid(imem_valid),
    .imem_rdata(a_rdata), .acc_zero(acc_zero), .op_code(a_opc),
    .reg_addr(a_ra), .alu_en(a_alu), .acc_ce(a_acc), .reg_ce(a_rce),
    .pc(a_pc), .halted(a_halt), .state(a_state)
  );

  seq_ctrl #(.WRAP_EN(1)) dut_b (
    .clk(clk), .rstn(rstn), .run(run), .prog_load(prog_load),
    .imem_req(b_req), .imem_addr(b_addr), .imem_valid(imem_valid),
    .imem_rdata(b_rdata), .acc_zero(acc_zero), .op_code(b_opc),
    .reg_addr(b_ra), .alu_en(b_alu), .acc_ce(b_acc), .reg_ce(b_rce),
    .pc(b_pc), .halted(b_halt), .state(b_state)
  );

  // {imem_req, halted, alu_en, acc_ce, reg_ce[3:0]}
  function automatic logic [7:0] outs_a();
    return {a_req, a_halt, a_alu, a_acc, a_rce};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start();
    @(negedge clk);
    run = 1'b1;
    @(posedge clk);
    #1 run = 1'b0;
    m_pc  = 0;
    m_end = 1'b0;
  endtask

  task automatic do_load();
    @(negedge clk);
    prog_load = 1'b1;
    @(negedge clk);
    chk("load_state", a_state, 0);
    chk("load_pc", a_pc, 0);
    chk("load_outs", outs_a(), 0);
    prog_load = 1'b0;
  endtask

  // Runs one instruction through DUT A, starting just before its FETCH
  // negedge. az: 0/1 forces acc_zero, 2 randomises it.
  task automatic exec_instr(input int waits, input int az, output bit hlt);
    logic [7:0] ins, e_outs;
    logic [2:0] opc;
    logic [4:0] opnd;
    int         iaddr;
    bit         self_jmp;
    hlt      = 1'b0;
    self_jmp = 1'b0;
    for (int w = 0; w <= waits; w++) begin
      @(negedge clk);
      chk("fetch_outs", outs_a(), 8'h80);
      chk("fetch_addr", a_addr, m_pc);
      imem_valid = (w == waits);
    end
    ins   = mem[m_pc];
    opc   = ins[7:5];
    opnd  = ins[4:0];
    iaddr = m_pc;
    if (m_pc == 31) m_end = 1'b1;
    else            m_pc  = m_pc + 1;
    @(negedge clk);
    imem_valid = 1'b0;
    chk("decode_outs", outs_a(), 0);
    acc_zero = (az == 2) ? ($urandom_range(0, 1) == 1) : (az == 1);
    @(negedge clk);
    chk("exec_opc", a_opc, opc);
    chk("exec_ra", a_ra, opnd[1:0]);
    chk("exec_outs", outs_a(), (opc < 4) ? 8'h20 : 8'h00);
    if ((opc == 6 && acc_zero) || opc == 7) begin
      self_jmp = (opc == 7) && (int'(opnd) == iaddr);
      m_pc     = opnd;
      m_end    = 1'b0;
    end
    @(negedge clk);
    if (self_jmp) begin
      chk("halt_outs", outs_a(), 8'h40);
      chk("halt_pc", a_pc, m_pc);
      chk("halt_state", a_state, 5);
      hlt = 1'b1;
    end else begin
      e_outs = 8'h00;
      if (opc <= 4) e_outs = 8'h10;
      if (opc == 5 && opnd < 4) e_outs = 8'(1 << opnd);
      chk("wb_outs", outs_a(), e_outs);
      chk("wb_pc", a_pc, m_pc);
      if (m_end) begin
        @(negedge clk);
        chk("end_halt_outs", outs_a(), 8'h40);
        chk("end_halt_pc", a_pc, m_pc);
        hlt = 1'b1;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit h;
    rstn = 1'b0; run = 1'b0; prog_load = 1'b0; imem_valid = 1'b0; acc_zero = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    m_pc = 0; m_end = 1'b0;

    // Reset values
    #12;
    chk("rst_outs", outs_a(), 0);
    chk("rst_pc", a_pc, 0);
    chk("rst_state", a_state, 0);
    chk("rst_opc_ra", {a_opc, a_ra}, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("idle_hold", a_state, 0);

    // ADD r1; ST r2; JMP self
    mem[0] = 8'h01; mem[1] = 8'hA2; mem[2] = 8'hE2;
    start();
    exec_instr(0, 2, h);
    exec_instr(0, 2, h);
    exec_instr(0, 2, h);
    chk("p1_halted", a_halt, 1);
    chk("p1_pc", a_pc, 2);

    // Same program restarted from HALT with a 3-cycle stall on the first fetch
    start();
    exec_instr(3, 2, h);
    exec_instr(0, 2, h);
    exec_instr(0, 2, h);

    // BRZ 10 taken, JMP 0, BRZ not taken, JMP self
    do_load();
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem[0] = 8'hCA; mem[10] = 8'hE0; mem[1] = 8'hE1;
    start();
    exec_instr(0, 1, h);
    exec_instr(0, 2, h);
    exec_instr(0, 0, h);
    exec_instr(0, 2, h);

    // Top of memory: A halts at 31, B wraps to 0
    do_load();
    mem[0] = 8'hFF; mem[31] = 8'h00;
    start();
    exec_instr(0, 2, h);
    exec_instr(0, 2, h);
    chk("wrap_a_halt", a_halt, 1);
    chk("wrap_a_pc", a_pc, 31);
    chk("wrap_b_req", b_req, 1);
    chk("wrap_b_addr", b_addr, 0);
    chk("wrap_b_halt", b_halt, 0);

    // prog_load during EXEC of ST abandons it; run is ignored meanwhile
    do_load();
    mem[0] = 8'hA0;
    start();
    @(negedge clk); imem_valid = 1'b1;
    @(negedge clk); imem_valid = 1'b0;
    @(negedge clk);
    chk("pl_exec_outs", outs_a(), 0);
    prog_load = 1'b1; run = 1'b1;
    @(negedge clk);
    chk("pl_state", a_state, 0);
    chk("pl_pc", a_pc, 0);
    chk("pl_no_wb", outs_a(), 0);
    @(negedge clk);
    chk("pl_run_ignored", a_state, 0);
    prog_load = 1'b0; run = 1'b0;
    @(negedge clk);
    chk("pl_idle_stay", a_state, 0);

    // Async reset during WRITE_BACK of ADD
    mem[0] = 8'h01;
    start();
    @(negedge clk); imem_valid = 1'b1;
    @(negedge clk); imem_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rwb_acc_ce", outs_a(), 8'h10);
    chk("rwb_pc", a_pc, 1);
    #2 rstn = 1'b0;
    #1;
    chk("rwb_outs", outs_a(), 0);
    chk("rwb_state", a_state, 0);
    chk("rwb_pc0", a_pc, 0);
    @(negedge clk); rstn = 1'b1;

    // Async reset mid-fetch drops imem_req immediately
    start();
    @(negedge clk);
    chk("rf_req_hi", a_req, 1);
    #2 rstn = 1'b0;
    #1;
    chk("rf_req_lo", a_req, 0);
    @(negedge clk); rstn = 1'b1;

    // Random programs, random stalls and random acc_zero
    for (int p = 0; p < 8; p++) begin
      do_load();
      for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
      start();
      for (int k = 0; k < 40; k++) begin
        exec_instr($urandom_range(0, 3), 2, h);
        if (h) start();
      end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
